// File: rtl/fetch_unit.sv
// Instruction fetch front end: direct-mapped I-cache, single-line refill FSM, next-PC prediction
// and a decoupling fetch queue. Define FETCH_UNIT_BHT_EN to add the 2-bit branch history table.
module fetch_unit #(
    parameter int unsigned IC_SETS     = 16,
    parameter int unsigned LINE_WORDS  = 16,
    parameter int unsigned BHT_ENTRIES = 256,
    parameter int unsigned FQ_DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [31:0]                out_pc,
    output logic                       out_pred_taken,
    output logic                       mc_req,
    output logic [31:0]                mc_addr,
    input  logic                       mc_done,
    input  logic [32*LINE_WORDS-1:0]   mc_data,
    input  logic                       flush_en,
    input  logic [31:0]                flush_pc,
    input  logic                       br_upd,
    input  logic                       br_taken,
    input  logic [31:0]                br_pc
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(IC_SETS);
    localparam int unsigned TAG_W = 32 - OFF_W - IDX_W - 2;
    localparam int unsigned FQ_W  = $clog2(FQ_DEPTH);
    localparam logic [FQ_W:0] FQ_FULL = (FQ_W + 1)'(FQ_DEPTH);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [0:0] {StIdle, StRefill} state_e;

    state_e            state_q;
    logic              mc_req_q;
    logic [31:0]       mc_addr_q;
    logic [31:0]       pc_q;
    logic [IC_SETS-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q [IC_SETS];
    logic [31:0]       data_q [IC_SETS][LINE_WORDS];

    logic [31:0]       fq_inst_q [FQ_DEPTH];
    logic [31:0]       fq_pc_q [FQ_DEPTH];
    logic              fq_pred_q [FQ_DEPTH];
    logic [FQ_W-1:0]   fq_head_q;
    logic [FQ_W-1:0]   fq_tail_q;
    logic [FQ_W:0]     fq_cnt_q;

    logic [OFF_W-1:0]  pc_off;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [IDX_W-1:0]  ref_idx;
    logic [TAG_W-1:0]  ref_tag;
    logic              hit;
    logic [31:0]       inst;
    logic [31:0]       imm_j;
    logic [31:0]       imm_b;
    logic [31:0]       next_pc;
    logic              pred_taken;
    logic              bht_taken;
    logic              push;
    logic              pop;
    logic              unused_bits;

    assign pc_off  = pc_q[OFF_W+1:2];
    assign pc_idx  = pc_q[OFF_W+IDX_W+1:OFF_W+2];
    assign pc_tag  = pc_q[31:OFF_W+IDX_W+2];
    assign ref_idx = mc_addr_q[OFF_W+IDX_W+1:OFF_W+2];
    assign ref_tag = mc_addr_q[31:OFF_W+IDX_W+2];
    assign hit     = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign inst    = data_q[pc_idx][pc_off];

`ifdef FETCH_UNIT_BHT_EN
    localparam int unsigned BHT_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [BHT_W-1:0] bht_rd_idx;
    logic [BHT_W-1:0] bht_wr_idx;

    assign bht_rd_idx = pc_q[BHT_W+1:2];
    assign bht_wr_idx = br_pc[BHT_W+1:2];
    // Lookup reads the pre-update counter when both hit the same entry.
    assign bht_taken  = bht_q[bht_rd_idx][1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'd0;
            end
        end else if (rdy && br_upd) begin
            if (br_taken && bht_q[bht_wr_idx] != 2'd3) begin
                bht_q[bht_wr_idx] <= bht_q[bht_wr_idx] + 2'd1;
            end else if (!br_taken && bht_q[bht_wr_idx] != 2'd0) begin
                bht_q[bht_wr_idx] <= bht_q[bht_wr_idx] - 2'd1;
            end
        end
    end

    assign unused_bits = ^{pc_q[1:0], mc_addr_q[OFF_W+1:0], br_pc[31:BHT_W+2], br_pc[1:0]};
`else
    assign bht_taken   = 1'b0;
    assign unused_bits = ^{pc_q[1:0], mc_addr_q[OFF_W+1:0], br_upd, br_taken, br_pc};
`endif

    always_comb begin
        imm_j      = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        imm_b      = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        pred_taken = 1'b0;
        next_pc    = pc_q + 32'd4;
        if (inst[6:0] == OP_JAL) begin
            pred_taken = 1'b1;
            next_pc    = pc_q + imm_j;
        end else if (inst[6:0] == OP_BRANCH && bht_taken) begin
            pred_taken = 1'b1;
            next_pc    = pc_q + imm_b;
        end
    end

    assign out_valid      = (fq_cnt_q != '0);
    assign out_inst       = out_valid ? fq_inst_q[fq_head_q] : 32'd0;
    assign out_pc         = out_valid ? fq_pc_q[fq_head_q] : 32'd0;
    assign out_pred_taken = out_valid ? fq_pred_q[fq_head_q] : 1'b0;

    assign pop  = rdy && out_valid && out_ready;
    assign push = rdy && !flush_en && hit && ((fq_cnt_q != FQ_FULL) || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= 32'd0;
            fq_head_q <= '0;
            fq_tail_q <= '0;
            fq_cnt_q  <= '0;
        end else if (rdy) begin
            if (flush_en) begin
                pc_q      <= flush_pc;
                fq_head_q <= '0;
                fq_tail_q <= '0;
                fq_cnt_q  <= '0;
            end else begin
                if (push) begin
                    pc_q                 <= next_pc;
                    fq_inst_q[fq_tail_q] <= inst;
                    fq_pc_q[fq_tail_q]   <= pc_q;
                    fq_pred_q[fq_tail_q] <= pred_taken;
                    fq_tail_q            <= fq_tail_q + 1'b1;
                end
                if (pop) begin
                    fq_head_q <= fq_head_q + 1'b1;
                end
                if (push && !pop) begin
                    fq_cnt_q <= fq_cnt_q + 1'b1;
                end else if (pop && !push) begin
                    fq_cnt_q <= fq_cnt_q - 1'b1;
                end
            end
        end
    end

    // Refill runs to completion even across a flush; the new PC is looked up again in StIdle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mc_req_q  <= 1'b0;
            mc_addr_q <= 32'd0;
            valid_q   <= '0;
        end else if (rdy) begin
            unique case (state_q)
                StIdle: begin
                    if (!flush_en && !hit) begin
                        state_q   <= StRefill;
                        mc_req_q  <= 1'b1;
                        mc_addr_q <= {pc_tag, pc_idx, {(OFF_W + 2){1'b0}}};
                    end
                end
                StRefill: begin
                    if (mc_done) begin
                        state_q          <= StIdle;
                        mc_req_q         <= 1'b0;
                        valid_q[ref_idx] <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && state_q == StRefill && mc_done) begin
            tag_q[ref_idx] <= ref_tag;
            for (int w = 0; w < LINE_WORDS; w++) begin
                data_q[ref_idx][w] <= mc_data[w*32 +: 32];
            end
        end
    end

    assign mc_req  = mc_req_q;
    assign mc_addr = mc_addr_q;

endmodule
